ddr_deserializer: RTL and testbench



---
 rtl/ddr_deser_pkg.sv | 18 +
 rtl/ddr_deserializer_if.sv | 27 ++
 rtl/ddr_in_pair.sv | 41 ++++
 rtl/ddr_deserializer.sv | 95 +++++++++
 tb/tb_ddr_deserializer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ddr_deser_pkg.sv
// Shared sizing helpers for the DDR input deserializer.
// Widths are derived from the bus width and the pairs-per-word ratio.
package ddr_deser_pkg;

    function automatic int out_width(input int data_width, input int ratio);
        return 2 * data_width * ratio;
    endfunction

    function automatic int cnt_width(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    // LSB position of assembly slot 'slot'; a slot holds one rise/fall pair.
    function automatic int slot_lsb(input int data_width, input int slot);
        return 2 * data_width * slot;
    endfunction

endpackage

// File: rtl/ddr_deserializer_if.sv
// Data/handshake bundle between the DDR deserializer and its neighbours.
// 'slave' is the deserializer side, 'master' drives DDR data and consumes words.
interface ddr_deserializer_if
    import ddr_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int RATIO      = 4
);
    logic [DATA_WIDTH-1:0]                        din;
    logic                                         din_en;
    logic                                         bitslip;
    logic [out_width(DATA_WIDTH, RATIO)-1:0]      dout_data;
    logic                                         dout_vld;
    logic                                         dout_rd;
    logic                                         overflow;
    logic                                         overflow_clr;

    modport slave (
        input  din, din_en, bitslip, dout_rd, overflow_clr,
        output dout_data, dout_vld, overflow
    );

    modport master (
        output din, din_en, bitslip, dout_rd, overflow_clr,
        input  dout_data, dout_vld, overflow
    );
endinterface

// File: rtl/ddr_in_pair.sv
// Dual-edge input capture: rise sample and qualifier on the rising edge,
// fall sample on the falling edge. Only logic in the design on the falling edge.
module ddr_in_pair #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_en,
    output logic [DATA_WIDTH-1:0] rise_q,
    output logic [DATA_WIDTH-1:0] fall_q,
    output logic                  en_q
);
    logic [DATA_WIDTH-1:0] rise_d;
    logic [DATA_WIDTH-1:0] fall_d;
    logic                  en_d;

    always_comb begin
        rise_d = din;
        fall_d = din;
        en_d   = din_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= '0;
            en_q   <= 1'b0;
        end else begin
            rise_q <= rise_d;
            en_q   <= en_d;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            fall_q <= '0;
        end else begin
            fall_q <= fall_d;
        end
    end
endmodule

// File: rtl/ddr_deserializer.sv
// DDR-to-SDR deserializer: packs RATIO rise/fall pairs (first pair in the LSBs)
// into one word, offered on a valid/ready output with sticky overflow.
module ddr_deserializer
    import ddr_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int RATIO      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ddr_deserializer_if.slave bus
);
    localparam int OUT_WIDTH  = out_width(DATA_WIDTH, RATIO);
    localparam int CNT_WIDTH  = cnt_width(RATIO);
    localparam int PAIR_WIDTH = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

    logic [DATA_WIDTH-1:0] rise_q;
    logic [DATA_WIDTH-1:0] fall_q;
    logic                  en_q;

    ddr_in_pair #(.DATA_WIDTH(DATA_WIDTH)) u_in_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (bus.din),
        .din_en (bus.din_en),
        .rise_q (rise_q),
        .fall_q (fall_q),
        .en_q   (en_q)
    );

    logic [PAIR_WIDTH-1:0] pair;
    logic                  pair_vld;
    logic                  word_done;
    logic                  xfer;

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  slots_q, slots_d;
    logic [OUT_WIDTH-1:0]  dout_data_q, dout_data_d;
    logic                  dout_vld_q, dout_vld_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        pair      = {rise_q, fall_q};
        // A bitslip cycle swallows the pair even when it is enabled.
        pair_vld  = en_q && !bus.bitslip;
        word_done = pair_vld && (cnt_q == CNT_LAST);
        xfer      = dout_vld_q && bus.dout_rd;

        cnt_d       = cnt_q;
        slots_d     = slots_q;
        dout_data_d = dout_data_q;
        dout_vld_d  = dout_vld_q;
        overflow_d  = overflow_q;

        if (pair_vld) begin
            slots_d[slot_lsb(DATA_WIDTH, int'(cnt_q)) +: PAIR_WIDTH] = pair;
            cnt_d = word_done ? '0 : cnt_q + CNT_WIDTH'(1);
        end

        // A completing word may replace the one being transferred this cycle.
        if (word_done && (!dout_vld_q || bus.dout_rd)) begin
            dout_data_d = slots_d;
            dout_vld_d  = 1'b1;
        end else if (xfer) begin
            dout_vld_d  = 1'b0;
        end

        if (word_done && dout_vld_q && !bus.dout_rd) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            slots_q     <= '0;
            dout_data_q <= '0;
            dout_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slots_q     <= slots_d;
            dout_data_q <= dout_data_d;
            dout_vld_q  <= dout_vld_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.dout_data = dout_data_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ddr_deserializer.sv
// Directed bench for ddr_deserializer with DATA_WIDTH=1, RATIO=4 (8-bit words).
// Each drive_pair call presents one rise/fall pair around a single rising edge.
module tb_ddr_deserializer;
    import ddr_deser_pkg::*;

    localparam int DATA_WIDTH = 1;
    localparam int RATIO      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ddr_deserializer_if #(.DATA_WIDTH(DATA_WIDTH), .RATIO(RATIO)) bus ();

    ddr_deserializer #(.DATA_WIDTH(DATA_WIDTH), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Rise value before the rising edge, fall value (and bitslip for this pair) after it.
    task automatic drive_pair(input logic r, input logic f, input logic en, input logic bs);
        @(negedge clk); #1;
        bus.din    = r;
        bus.din_en = en;
        @(posedge clk); #1;
        bus.din     = f;
        bus.bitslip = bs;
    endtask

    task automatic idle();
        drive_pair(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Slot k of word w is {w[2k+1], w[2k]} = {rise, fall}.
    task automatic send_slots(input logic [7:0] w, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            drive_pair(w[2*k+1], w[2*k], 1'b1, 1'b0);
        end
    endtask

    initial begin
        bus.din          = '0;
        bus.din_en       = 1'b0;
        bus.bitslip      = 1'b0;
        bus.dout_rd      = 1'b1;
        bus.overflow_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",  32'(bus.dout_vld),  32'h0);
        chk("rst_data", 32'(bus.dout_data), 32'h0);
        chk("rst_ovf",  32'(bus.overflow),  32'h0);
        rst_n = 1'b1;

        // Basic word: pairs 10,00,11,10 -> 0xB2
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        chk("basic_pre_vld", 32'(bus.dout_vld), 32'h0);
        idle();
        chk("basic_vld",  32'(bus.dout_vld),  32'h1);
        chk("basic_data", 32'(bus.dout_data), 32'hB2);
        idle();
        chk("basic_vld_drop", 32'(bus.dout_vld), 32'h0);

        // Gapped enable: disabled pairs carry junk that must be ignored
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap_pre_vld", 32'(bus.dout_vld), 32'h0);
        idle();
        chk("gap_vld",  32'(bus.dout_vld),  32'h1);
        chk("gap_data", 32'(bus.dout_data), 32'hB2);
        idle();

        // Backpressure: second word dropped, first held
        bus.dout_rd = 1'b0;
        send_slots(8'h5A, 0, 3);
        idle();
        chk("bp_first_vld",  32'(bus.dout_vld),  32'h1);
        chk("bp_first_data", 32'(bus.dout_data), 32'h5A);
        chk("bp_first_ovf",  32'(bus.overflow),  32'h0);
        send_slots(8'hC3, 0, 3);
        idle();
        chk("bp_hold_vld",  32'(bus.dout_vld),  32'h1);
        chk("bp_hold_data", 32'(bus.dout_data), 32'h5A);
        chk("bp_ovf_set",   32'(bus.overflow),  32'h1);
        idle();
        chk("bp_ovf_sticky", 32'(bus.overflow), 32'h1);
        bus.overflow_clr = 1'b1;
        idle();
        bus.overflow_clr = 1'b0;
        chk("bp_ovf_clr",     32'(bus.overflow),  32'h0);
        chk("bp_clr_vld",     32'(bus.dout_vld),  32'h1);
        chk("bp_clr_data",    32'(bus.dout_data), 32'h5A);
        bus.dout_rd = 1'b1;
        idle();
        chk("bp_xfer_vld", 32'(bus.dout_vld), 32'h0);

        // Completion coinciding with a transfer of the pending word: no bubble
        bus.dout_rd = 1'b0;
        send_slots(8'h12, 0, 3);
        send_slots(8'h34, 0, 0);
        chk("b2b_first_vld",  32'(bus.dout_vld),  32'h1);
        chk("b2b_first_data", 32'(bus.dout_data), 32'h12);
        send_slots(8'h34, 1, 3);
        chk("b2b_held_data", 32'(bus.dout_data), 32'h12);
        bus.dout_rd = 1'b1;
        idle();
        chk("b2b_second_vld",  32'(bus.dout_vld),  32'h1);
        chk("b2b_second_data", 32'(bus.dout_data), 32'h34);
        chk("b2b_no_ovf",      32'(bus.overflow),  32'h0);
        idle();
        chk("b2b_drain_vld", 32'(bus.dout_vld), 32'h0);

        // Bitslip at pair 0 of 10,00,11,10,01: word is 00,11,10,01 LSB-first = 0x6C
        drive_pair(1'b1, 1'b0, 1'b1, 1'b1);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("slip_vld",  32'(bus.dout_vld),  32'h1);
        chk("slip_data", 32'(bus.dout_data), 32'h6C);
        idle();

        // Bitslip on the completing pair defers completion by one valid pair
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b1);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0);
        chk("slip_done_defer", 32'(bus.dout_vld), 32'h0);
        idle();
        chk("slip_done_vld",  32'(bus.dout_vld),  32'h1);
        chk("slip_done_data", 32'(bus.dout_data), 32'h39);
        idle();

        // Reset mid-word: partial word discarded, next word aligns from slot 0
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("mid_rst_vld",  32'(bus.dout_vld),  32'h0);
        chk("mid_rst_data", 32'(bus.dout_data), 32'h0);
        chk("mid_rst_ovf",  32'(bus.overflow),  32'h0);
        idle();
        chk("mid_rst_quiet", 32'(bus.dout_vld), 32'h0);
        send_slots(8'hA5, 0, 3);
        idle();
        chk("post_rst_vld",  32'(bus.dout_vld),  32'h1);
        chk("post_rst_data", 32'(bus.dout_data), 32'hA5);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
